// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module : hazard_ctrl_pkg
// Brief  : Shared defaults and FSM state encoding for the ID->EX hazard controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam int c_NUM_REGS_DEF     = 32;
    localparam int c_FLUSH_CYCLES_DEF = 2;
    localparam int c_CNT_W_DEF        = 16;
    localparam int c_FCNT_W           = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module : hazard_ctrl_if
// Brief  : ID/WB/EX-side signals and issue-control outputs of the hazard controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int REG_SEL = 5,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [REG_SEL-1:0] id_rs1;
    logic [REG_SEL-1:0] id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [REG_SEL-1:0] id_rd;
    logic               id_reg_write;
    logic               wb_valid;
    logic [REG_SEL-1:0] wb_rd;
    logic               ex_redirect;
    logic               issue;
    logic               stall_if_id;
    logic               bubble_ex;
    logic               flush_if_id;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
        output wb_valid, wb_rd, ex_redirect,
        input  issue, stall_if_id, bubble_ex, flush_if_id, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
        input  wb_valid, wb_rd, ex_redirect,
        output issue, stall_if_id, bubble_ex, flush_if_id, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_scoreboard.sv
// ============================================================================
// Module : hazard_ctrl_scoreboard
// Brief  : Pending-write bit per register; set beats clear, x0 never pending.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = c_NUM_REGS_DEF,
    parameter int REG_SEL  = $clog2(NUM_REGS)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_set,
    input  wire logic [REG_SEL-1:0] i_set_sel,
    input  wire logic               i_clr,
    input  wire logic [REG_SEL-1:0] i_clr_sel,
    input  wire logic [REG_SEL-1:0] i_rd_sel_a,
    input  wire logic [REG_SEL-1:0] i_rd_sel_b,
    input  wire logic [REG_SEL-1:0] i_rd_sel_c,
    output logic                    o_pend_a,
    output logic                    o_pend_b,
    output logic                    o_pend_c
);

    logic [NUM_REGS-1:0] w_pend;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        if (i == 0) begin : g_zero
            assign w_pend[i] = 1'b0;
        end else begin : g_flop
            logic r_bit;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_bit <= 1'b0;
                end else if (i_set && (i_set_sel == REG_SEL'(i))) begin
                    r_bit <= 1'b1;
                end else if (i_clr && (i_clr_sel == REG_SEL'(i))) begin
                    r_bit <= 1'b0;
                end
            end
            assign w_pend[i] = r_bit;
        end
    end

    assign o_pend_a = w_pend[i_rd_sel_a];
    assign o_pend_b = w_pend[i_rd_sel_b];
    assign o_pend_c = w_pend[i_rd_sel_c];

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : ID->EX issue/stall/flush sequencer with register scoreboard and stall counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = c_NUM_REGS_DEF,
    parameter int REG_SEL      = $clog2(NUM_REGS),
    parameter int FLUSH_CYCLES = c_FLUSH_CYCLES_DEF,
    parameter int CNT_W        = c_CNT_W_DEF
) (
    input wire logic     clk,
    input wire logic     rst,
    hazard_ctrl_if.slave bus
);

    // The redirect cycle itself is the first flush cycle; the counter holds the rest.
    localparam logic [c_FCNT_W-1:0] c_RELOAD = c_FCNT_W'(FLUSH_CYCLES - 1);

    state_e              r_state;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic w_pend_rs1;
    logic w_pend_rs2;
    logic w_pend_rd;
    logic w_hz;
    logic w_issue;
    logic w_stall;
    logic w_bubble;
    logic w_flush;
    logic w_set;

    hazard_ctrl_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_SEL  (REG_SEL)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set      (w_set),
        .i_set_sel  (bus.id_rd),
        .i_clr      (bus.wb_valid),
        .i_clr_sel  (bus.wb_rd),
        .i_rd_sel_a (bus.id_rs1),
        .i_rd_sel_b (bus.id_rs2),
        .i_rd_sel_c (bus.id_rd),
        .o_pend_a   (w_pend_rs1),
        .o_pend_b   (w_pend_rs2),
        .o_pend_c   (w_pend_rd)
    );

    assign w_hz  = (bus.id_use_rs1 & w_pend_rs1) |
                   (bus.id_use_rs2 & w_pend_rs2) |
                   (bus.id_reg_write & w_pend_rd);
    assign w_set = w_issue & bus.id_reg_write & (bus.id_rd != '0);

    always_comb begin
        w_issue  = 1'b0;
        w_stall  = 1'b0;
        w_bubble = 1'b1;
        w_flush  = 1'b1;
        if (rst && (r_state == ST_RUN)) begin
            w_issue  = bus.id_valid & ~w_hz & ~bus.ex_redirect;
            w_stall  = bus.id_valid & w_hz & ~bus.ex_redirect;
            w_bubble = ~w_issue;
            w_flush  = bus.ex_redirect;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_fcnt      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (bus.ex_redirect) begin
                r_fcnt  <= c_RELOAD;
                r_state <= (c_RELOAD == '0) ? ST_RUN : ST_FLUSH;
            end else if (r_state == ST_FLUSH) begin
                if (r_fcnt <= c_FCNT_W'(1)) begin
                    r_fcnt  <= '0;
                    r_state <= ST_RUN;
                end else begin
                    r_fcnt <= r_fcnt - 1'b1;
                end
            end
        end
    end

    assign bus.issue       = w_issue;
    assign bus.stall_if_id = w_stall;
    assign bus.bubble_ex   = w_bubble;
    assign bus.flush_if_id = w_flush;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed-vector bench for hazard_ctrl (CNT_W=4, FLUSH_CYCLES=2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int c_RS = 5;
    localparam int c_CW = 4;

    typedef struct {
        logic            rstn;
        logic            v;
        logic [c_RS-1:0] rs1;
        logic            u1;
        logic [c_RS-1:0] rs2;
        logic            u2;
        logic [c_RS-1:0] rd;
        logic            rw;
        logic            wbv;
        logic [c_RS-1:0] wbrd;
        logic            rdr;
        logic            e_issue;
        logic            e_stall;
        logic            e_bub;
        logic            e_flush;
        logic [c_CW-1:0] e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_applied;
    int   n_miscompares;

    hazard_ctrl_if #(.REG_SEL(c_RS), .CNT_W(c_CW)) bus ();

    hazard_ctrl #(
        .NUM_REGS     (32),
        .REG_SEL      (c_RS),
        .FLUSH_CYCLES (2),
        .CNT_W        (c_CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit rn, bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw,
                                bit wbv, int wbrd, bit rdr, bit ei, bit es, bit eb, bit ef, int ec);
        vec_t r;
        r.rstn = rn;  r.v = v;
        r.rs1  = c_RS'(rs1);  r.u1 = u1;
        r.rs2  = c_RS'(rs2);  r.u2 = u2;
        r.rd   = c_RS'(rd);   r.rw = rw;
        r.wbv  = wbv; r.wbrd = c_RS'(wbrd); r.rdr = rdr;
        r.e_issue = ei; r.e_stall = es; r.e_bub = eb; r.e_flush = ef; r.e_cnt = c_CW'(ec);
        return r;
    endfunction

    // Drive at the falling edge, compare 1 time unit later, state advances at the next rising edge.
    task automatic step(input vec_t t, input string name);
        @(negedge clk);
        rst               = t.rstn;
        bus.id_valid      = t.v;
        bus.id_rs1        = t.rs1;
        bus.id_use_rs1    = t.u1;
        bus.id_rs2        = t.rs2;
        bus.id_use_rs2    = t.u2;
        bus.id_rd         = t.rd;
        bus.id_reg_write  = t.rw;
        bus.wb_valid      = t.wbv;
        bus.wb_rd         = t.wbrd;
        bus.ex_redirect   = t.rdr;
        #1;
        n_applied++;
        if (bus.issue !== t.e_issue || bus.stall_if_id !== t.e_stall || bus.bubble_ex !== t.e_bub ||
            bus.flush_if_id !== t.e_flush || bus.stall_cnt !== t.e_cnt) begin
            n_miscompares++;
            $display("FAIL %s: got issue=%b stall=%b bubble=%b flush=%b cnt=%0d, want issue=%b stall=%b bubble=%b flush=%b cnt=%0d",
                     name, bus.issue, bus.stall_if_id, bus.bubble_ex, bus.flush_if_id, bus.stall_cnt,
                     t.e_issue, t.e_stall, t.e_bub, t.e_flush, t.e_cnt);
        end
    endtask

    vec_t tbl[21];

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        rst = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0; bus.id_rd = '0; bus.id_reg_write = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.ex_redirect = 1'b0;
        repeat (2) @(posedge clk);

        //           rn v  rs1 u1 rs2 u2 rd rw wbv wbrd rdr | iss stl bub fl cnt
        tbl[0]  = mk(0, 1,  5, 1,  0, 0,  3, 1, 0,  0, 0,    0,  0,  1, 1, 0);  // reset
        tbl[1]  = mk(0, 1,  5, 1,  0, 0,  3, 1, 0,  0, 1,    0,  0,  1, 1, 0);
        tbl[2]  = mk(0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,    0,  0,  1, 1, 0);
        tbl[3]  = mk(1, 1,  0, 0,  0, 0,  5, 1, 0,  0, 0,    1,  0,  0, 0, 0);  // issue rd=5
        tbl[4]  = mk(1, 1,  5, 1,  0, 0,  6, 1, 0,  0, 0,    0,  1,  1, 0, 0);  // RAW stall
        tbl[5]  = mk(1, 1,  5, 1,  0, 0,  6, 1, 1,  5, 0,    0,  1,  1, 0, 1);  // wb x5 at N
        tbl[6]  = mk(1, 1,  5, 1,  0, 0,  6, 1, 0,  0, 0,    1,  0,  0, 0, 2);  // issue at N+1
        tbl[7]  = mk(1, 1,  0, 0,  0, 0,  0, 1, 0,  0, 0,    1,  0,  0, 0, 2);  // rd=x0
        tbl[8]  = mk(1, 1,  0, 1,  0, 0,  7, 1, 0,  0, 0,    1,  0,  0, 0, 2);  // rs1=x0, set x7
        tbl[9]  = mk(1, 1,  0, 1,  7, 0,  0, 0, 0,  0, 0,    1,  0,  0, 0, 2);  // x7 unused
        tbl[10] = mk(1, 1,  0, 1,  7, 1,  0, 0, 0,  0, 0,    0,  1,  1, 0, 2);  // x7 used
        tbl[11] = mk(1, 1,  0, 0,  0, 0,  9, 1, 1,  9, 0,    1,  0,  0, 0, 3);  // set/clr x9
        tbl[12] = mk(1, 1,  9, 1,  0, 0,  0, 0, 0,  0, 0,    0,  1,  1, 0, 3);  // set won
        tbl[13] = mk(1, 1,  9, 1,  0, 0,  0, 0, 0,  0, 1,    0,  0,  1, 1, 4);  // redirect
        tbl[14] = mk(1, 1,  9, 1,  0, 0,  0, 0, 0,  0, 0,    0,  0,  1, 1, 4);  // FLUSH
        tbl[15] = mk(1, 1,  9, 1,  0, 0,  0, 0, 0,  0, 0,    0,  1,  1, 0, 4);  // back in RUN
        tbl[16] = mk(1, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1,    0,  0,  1, 1, 5);  // redirect
        tbl[17] = mk(1, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1,    0,  0,  1, 1, 5);  // 2nd in FLUSH
        tbl[18] = mk(1, 0,  0, 0,  0, 0,  0, 0, 1,  9, 0,    0,  0,  1, 1, 5);  // drain x9
        tbl[19] = mk(1, 1,  9, 1,  0, 0,  0, 0, 0,  0, 0,    1,  0,  0, 0, 5);
        tbl[20] = mk(1, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,    0,  0,  1, 0, 5);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // x6 is still pending: 20 back-to-back stalls must pin the counter at 15.
        for (int i = 0; i < 20; i++) begin
            step(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, (5 + i > 15) ? 15 : 5 + i),
                 $sformatf("sat%0d", i));
        end
        step(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 15), "sat_hold");

        // Reset while in FLUSH, then confirm state, counter and scoreboard all cleared.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 15), "mid_redirect");
        step(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 15), "mid_rst_assert");
        step(mk(1, 1, 6, 1, 7, 1, 9, 1, 0, 0, 0, 1, 0, 0, 0, 0),  "post_rst_clear");
        step(mk(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),  "post_rst_track");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
